// File: rtl/layer_1_pkg.sv
// Shared geometry, state encoding and counter widths for the layer-1 frame loader.
package layer_1_pkg;

  localparam int ROW_WIDTH          = 16;
  localparam int NUM_ROWS           = 16;
  localparam int LAYER_1_INPUT_SIZE = ROW_WIDTH * NUM_ROWS;
  localparam int ROW_CNT_W          = $clog2(NUM_ROWS);

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    FULL  = 2'd1,
    ISSUE = 2'd2,
    WAIT  = 2'd3
  } state_t;

endpackage

// File: rtl/layer_1_timeout_counter.sv
// Free-running cycle counter for the load handshake; expired flags the last allowed cycle.
module layer_1_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_r;

  // Count while enabled; clear has priority so each handshake starts from zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (clear) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (enable) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign expired = (cnt_r == LAST_CNT);

endmodule

// File: rtl/layer_1_frame_loader.sv
// Collects a 16x16 binary frame row by row, then hands it to layer 1 with a
// load/done handshake guarded by a timeout.
module layer_1_frame_loader
  import layer_1_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [ROW_WIDTH-1:0]          row_data,
  input  logic                          row_valid,
  input  logic                          row_last,
  output logic                          row_ready,
  output logic [LAYER_1_INPUT_SIZE-1:0] layer_1_input,
  output logic                          load,
  input  logic                          done_complete,
  output logic                          busy,
  output logic                          frame_done,
  output logic                          error
);

  localparam logic [ROW_CNT_W-1:0] LAST_ROW = ROW_CNT_W'(NUM_ROWS - 1);

  state_t               state_r;
  logic [ROW_CNT_W-1:0] row_cnt_r;
  logic                 accept_s;
  logic                 last_slot_s;
  logic                 tmo_clear_s;
  logic                 tmo_enable_s;
  logic                 tmo_expired_s;

  assign row_ready    = (state_r == FILL) && !reset;
  assign busy         = (state_r == ISSUE) || (state_r == WAIT);
  assign accept_s     = row_valid && row_ready;
  assign last_slot_s  = (row_cnt_r == LAST_ROW);
  // The counter sits at zero through ISSUE, so the WAIT cycles see 1..TIMEOUT_CYCLES-1.
  assign tmo_clear_s  = (state_r == FILL) || (state_r == FULL);
  assign tmo_enable_s = busy;

  layer_1_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clear  (tmo_clear_s),
    .enable (tmo_enable_s),
    .expired(tmo_expired_s)
  );

  // Frame FSM with row counter, frame vector and registered handshake/status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= FILL;
      row_cnt_r     <= {ROW_CNT_W{1'b0}};
      layer_1_input <= {LAYER_1_INPUT_SIZE{1'b0}};
      load          <= 1'b0;
      frame_done    <= 1'b0;
      error         <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      error      <= 1'b0;
      case (state_r)
        FILL: begin
          load <= 1'b0;
          if (accept_s) begin
            layer_1_input[row_cnt_r*ROW_WIDTH +: ROW_WIDTH] <= row_data;
            if (row_last && last_slot_s) begin
              row_cnt_r <= {ROW_CNT_W{1'b0}};
              state_r   <= FULL;
            end else if (row_last || last_slot_s) begin
              // Short or unterminated frame: drop it and resynchronise on the next row.
              row_cnt_r <= {ROW_CNT_W{1'b0}};
              error     <= 1'b1;
            end else begin
              row_cnt_r <= row_cnt_r + ROW_CNT_W'(1);
            end
          end
        end
        FULL: begin
          // A done still high from the previous frame must clear before re-issuing.
          if (!done_complete) begin
            load    <= 1'b1;
            state_r <= ISSUE;
          end else begin
            load <= 1'b0;
          end
        end
        ISSUE: begin
          load    <= 1'b1;
          state_r <= WAIT;
        end
        WAIT: begin
          if (done_complete) begin
            frame_done <= 1'b1;
            load       <= 1'b0;
            row_cnt_r  <= {ROW_CNT_W{1'b0}};
            state_r    <= FILL;
          end else if (tmo_expired_s) begin
            error     <= 1'b1;
            load      <= 1'b0;
            row_cnt_r <= {ROW_CNT_W{1'b0}};
            state_r   <= FILL;
          end else begin
            load <= 1'b1;
          end
        end
        default: begin
          load      <= 1'b0;
          row_cnt_r <= {ROW_CNT_W{1'b0}};
          state_r   <= FILL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_layer_1_frame_loader.sv
// Directed bench for layer_1_frame_loader: a frame table plus hand-written reset and stale-done sequences.
module tb_layer_1_frame_loader;

  logic         clk = 1'b0;
  logic         reset;
  logic [15:0]  row_data;
  logic         row_valid;
  logic         row_last;
  logic         row_ready;
  logic [255:0] layer_1_input;
  logic         load;
  logic         done_complete;
  logic         busy;
  logic         frame_done;
  logic         error;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] cur_rows [16];

  always #5 clk = ~clk;

  layer_1_frame_loader #(.TIMEOUT_CYCLES(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .row_data     (row_data),
    .row_valid    (row_valid),
    .row_last     (row_last),
    .row_ready    (row_ready),
    .layer_1_input(layer_1_input),
    .load         (load),
    .done_complete(done_complete),
    .busy         (busy),
    .frame_done   (frame_done),
    .error        (error)
  );

  typedef struct {
    int pattern;     // 0 = diagonal, 1 = random rows
    int nrows;
    int last_idx;    // -1: row_last never set
    bit gaps;
    int done_delay;  // load cycles before done is raised, -1: never
    bit exp_ferr;
    int exp_load;
    bit exp_fd;
    bit exp_terr;
  } frame_vec_t;

  frame_vec_t vecs [8];

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [255:0] pack_rows(input int nrows);
    logic [255:0] v = '0;
    for (int r = 0; r < nrows; r++) v[r*16 +: 16] = cur_rows[r];
    return v;
  endfunction

  task automatic send_rows(input int nrows, input int last_idx, input bit gaps);
    for (int i = 0; i < nrows; i++) begin
      int b = 0;
      if (gaps) begin
        int g = int'($urandom_range(0, 2));
        for (int k = 0; k < g; k++) @(negedge clk);
      end
      @(negedge clk);
      row_data  = cur_rows[i];
      row_last  = (i == last_idx);
      row_valid = 1'b1;
      while (!row_ready && b < 20) begin
        @(negedge clk);
        b++;
      end
      if (b == 20) chk("row_ready_bound", {255'd0, row_ready}, 256'd1);
      @(posedge clk);
      #1;
      row_valid = 1'b0;
      row_last  = 1'b0;
    end
  endtask

  // Runs one handshake from the FULL cycle to the frame_done/error pulse.
  task automatic wait_result(input int dly, output bit finished, output int load_cyc,
                             output int rise_idx, output int fd_cnt, output int err_cnt,
                             output logic [255:0] vec_load, output logic [255:0] vec_end,
                             output logic rr_end);
    finished = 1'b0; load_cyc = 0; rise_idx = -1; fd_cnt = 0; err_cnt = 0;
    vec_load = '0; vec_end = '0; rr_end = 1'b0;
    for (int n = 1; n <= 60 && !finished; n++) begin
      @(negedge clk);
      if (frame_done) fd_cnt++;
      if (error) err_cnt++;
      if (frame_done || error) begin
        finished      = 1'b1;
        rr_end        = row_ready;
        vec_end       = layer_1_input;
        done_complete = 1'b0;
      end else if (load) begin
        load_cyc++;
        if (rise_idx < 0) begin
          rise_idx = n;
          vec_load = layer_1_input;
        end
        if (dly >= 0 && load_cyc == dly) done_complete = 1'b1;
      end
    end
    @(negedge clk);
    if (frame_done) fd_cnt++;
    if (error) err_cnt++;
  endtask

  task automatic fill_rows(input int pattern);
    for (int r = 0; r < 16; r++)
      cur_rows[r] = (pattern == 0) ? (16'h0001 << r) : 16'($urandom());
  endtask

  task automatic clean_frame(input string nm, input int dly);
    bit fin; int lc, ri, fc, ec; logic [255:0] vl, ve; logic rr;
    logic [255:0] exp_v;
    fill_rows(1);
    exp_v = pack_rows(16);
    send_rows(16, 15, 1'b0);
    wait_result(dly, fin, lc, ri, fc, ec, vl, ve, rr);
    chk({nm, "_finished"}, {255'd0, fin}, 256'd1);
    chk({nm, "_vector"}, vl, exp_v);
    chk({nm, "_frame_done_cnt"}, 256'(fc), 256'd1);
    chk({nm, "_error_cnt"}, 256'(ec), 256'd0);
  endtask

  initial begin
    bit fin; int lc, ri, fc, ec; logic [255:0] vl, ve; logic rr;
    logic [255:0] exp_v;
    int any_load;

    vecs[0] = '{0, 16, 15, 1'b0,  5, 1'b0, 5, 1'b1, 1'b0};
    vecs[1] = '{1, 10,  9, 1'b0,  0, 1'b1, 0, 1'b0, 1'b0};
    vecs[2] = '{1, 16, 15, 1'b0,  3, 1'b0, 3, 1'b1, 1'b0};
    vecs[3] = '{1, 16, -1, 1'b0,  0, 1'b1, 0, 1'b0, 1'b0};
    vecs[4] = '{1, 16, 15, 1'b0, -1, 1'b0, 8, 1'b0, 1'b1};
    vecs[5] = '{1, 16, 15, 1'b1,  2, 1'b0, 2, 1'b1, 1'b0};
    vecs[6] = '{1, 16, 15, 1'b1,  8, 1'b0, 8, 1'b1, 1'b0};
    vecs[7] = '{1, 16, 15, 1'b1,  4, 1'b0, 4, 1'b1, 1'b0};

    reset = 1'b1; row_data = 16'h0000; row_valid = 1'b0; row_last = 1'b0;
    done_complete = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_load", {255'd0, load}, 256'd0);
    chk("rst_busy", {255'd0, busy}, 256'd0);
    chk("rst_pulses", {254'd0, frame_done, error}, 256'd0);
    chk("rst_vector", layer_1_input, 256'd0);
    chk("rst_row_ready", {255'd0, row_ready}, 256'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_row_ready", {255'd0, row_ready}, 256'd1);

    for (int i = 0; i < 8; i++) begin
      fill_rows(vecs[i].pattern);
      if (vecs[i].pattern == 0) begin
        exp_v = '0;
        for (int r = 0; r < 16; r++) exp_v[r*17] = 1'b1;
      end else begin
        exp_v = pack_rows(16);
      end
      send_rows(vecs[i].nrows, vecs[i].last_idx, vecs[i].gaps);
      if (vecs[i].exp_ferr) begin
        @(negedge clk);
        chk($sformatf("v%0d_framing_error", i), {255'd0, error}, 256'd1);
        chk($sformatf("v%0d_ready_after_err", i), {255'd0, row_ready}, 256'd1);
        any_load = 0;
        repeat (4) begin
          @(negedge clk);
          if (load || error) any_load++;
        end
        chk($sformatf("v%0d_no_load_after_err", i), 256'(any_load), 256'd0);
      end else begin
        wait_result(vecs[i].done_delay, fin, lc, ri, fc, ec, vl, ve, rr);
        chk($sformatf("v%0d_finished", i), {255'd0, fin}, 256'd1);
        chk($sformatf("v%0d_load_rise", i), 256'(ri), 256'd2);
        chk($sformatf("v%0d_load_cycles", i), 256'(lc), 256'(vecs[i].exp_load));
        chk($sformatf("v%0d_frame_done_cnt", i), 256'(fc), 256'(vecs[i].exp_fd));
        chk($sformatf("v%0d_error_cnt", i), 256'(ec), 256'(vecs[i].exp_terr));
        chk($sformatf("v%0d_vector_at_load", i), vl, exp_v);
        chk($sformatf("v%0d_vector_at_end", i), ve, exp_v);
        chk($sformatf("v%0d_ready_at_end", i), {255'd0, rr}, 256'd1);
      end
    end

    // Stale done held high across the last row keeps the loader parked in FULL.
    fill_rows(1);
    exp_v = pack_rows(16);
    done_complete = 1'b1;
    send_rows(16, 15, 1'b0);
    any_load = 0;
    repeat (5) begin
      @(negedge clk);
      if (load || busy || row_ready) any_load++;
    end
    chk("stale_done_holds_full", 256'(any_load), 256'd0);
    done_complete = 1'b0;
    @(negedge clk);
    chk("stale_done_load_rise", {255'd0, load}, 256'd1);
    chk("stale_done_vector", layer_1_input, exp_v);
    wait_result(3, fin, lc, ri, fc, ec, vl, ve, rr);
    chk("stale_done_frame_done", 256'(fc), 256'd1);
    chk("stale_done_error", 256'(ec), 256'd0);

    // Reset asserted in WAIT clears everything on the next edge.
    fill_rows(1);
    send_rows(16, 15, 1'b0);
    repeat (3) @(negedge clk);
    chk("wait_load_high", {254'd0, load, busy}, 256'd3);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_load", {255'd0, load}, 256'd0);
    chk("mid_rst_vector", layer_1_input, 256'd0);
    chk("mid_rst_ready_busy", {254'd0, row_ready, busy}, 256'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_ready_after", {255'd0, row_ready}, 256'd1);

    clean_frame("after_rst", 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_time_limit: got expired expected finish");
    $fatal(1, "time limit");
  end

endmodule
